counter_job_scheduler: RTL and testbench
========================================

Name: counter_job_scheduler

Overview:
Shares one loadable up/down BIT_WIDTH counter among NUM_REQ requesters. Each requester submits a counting job (start value, end value, direction) over a valid/ready handshake. A round-robin arbiter picks one job, the block loads and runs the counter until it reaches the end value, then reports completion. The block sits between requester logic and the counter datapath and is the only driver of the counter's control inputs.

Parameters:
BIT_WIDTH, 4, counter width and job value width
NUM_REQ, 4, number of requesters (2..8)
IDXW, $clog2(NUM_REQ), width of the owner index

Ports:
CLK  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester job request; held high until accepted
req_start  input  NUM_REQ*BIT_WIDTH  job start value; slice i belongs to requester i
req_end  input  NUM_REQ*BIT_WIDTH  job end value; slice i belongs to requester i
req_up  input  NUM_REQ  job direction (1 = up, 0 = down)
req_ready  output  NUM_REQ  one-hot, one-cycle acceptance pulse
abort  input  1  kills the active job
cnt_out  input  BIT_WIDTH  current counter value
cnt_load_en  output  1  counter load strobe
cnt_load_val  output  BIT_WIDTH  value loaded into the counter
cnt_chnge  output  1  counter direction (1 = up)
cnt_run  output  1  counter count enable
cnt_reset  output  1  synchronous clear to the counter, active-high
busy  output  1  a job is owned
owner  output  IDXW  index of the current job owner
done  output  NUM_REQ  one-hot, one-cycle completion pulse
aborted  output  1  one-cycle pulse when a job is killed

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0. All outputs are 0 except cnt_reset, which is 1 while reset is low. Captured job registers are cleared.
- States: IDLE, GRANT, LOAD, RUN, DONE, ABORT.
- IDLE: if any req_valid bit is set, go to GRANT. The winner is the first set bit searched from rr_ptr upward, wrapping at NUM_REQ. The winner index is registered into owner.
- GRANT (1 cycle):
  - req_ready[owner]=1 and busy=1.
  - Capture req_start, req_end and req_up slices for owner.
  - rr_ptr := owner+1 mod NUM_REQ.
  - Go to LOAD.
- LOAD (1 cycle): cnt_load_en=1, cnt_load_val=start, cnt_chnge=dir, cnt_run=0. Go to RUN.
- RUN:
  - cnt_chnge=dir.
  - cnt_run = (cnt_out != end), decoded combinationally from state and cnt_out, so the counter halts exactly at end.
  - When cnt_out==end, go to DONE.
- DONE (1 cycle): done[owner]=1, cnt_run=0, busy=1. Go to IDLE; busy=0 from the next cycle. The counter holds end.
- Latency: req_valid first high at cycle 0 gives ready at cycle 1, load at cycle 2, and RUN from cycle 3. The done pulse occurs at cycle 4 + ((end-start) mod 2^BIT_WIDTH) for up jobs, and 4 + ((start-end) mod 2^BIT_WIDTH) for down jobs.
- Wrap-around is legal. An up job with end<start counts through 2^BIT_WIDTH-1 → 0. Down jobs mirror this.
- start==end: RUN sees the match in its first cycle, cnt_run stays 0, and done fires at cycle 4.
- abort: sampled in GRANT, LOAD or RUN.
  - If asserted, go to ABORT instead of the normal transition. Abort has priority over end-match in the same cycle.
  - GRANT still pulses req_ready, because the job was accepted.
  - ABORT (1 cycle): cnt_reset=1, cnt_run=0, aborted=1, done=0. Then go to IDLE.
  - abort in IDLE or DONE is ignored.
- req_valid dropped before ready is a requester protocol violation. The scheduler samples only in IDLE and in the GRANT cycle; no check is made.
- Job inputs are ignored outside the GRANT capture cycle. Changes to req_* during RUN do not affect the active job.
- Reset mid-job: immediate return to the reset state. No done or aborted pulse.
- Only one job is ever active. No queueing; other requesters wait with valid high.

Test Plan:
- Single job, BIT_WIDTH=4: req_valid[0], start=3, end=7, up → ready[0] at cycle 1, load_en with val=3 at cycle 2, done[0] at cycle 8, counter holds 7.
- Wrap-around: req 1, start=14, end=1, up → run lasts 3 counts (14→15→0→1), done[1] at cycle 7. Down job start=1, end=14 gives the same count length.
- Round-robin: req_valid=4'b1111 held, each requester re-asserting after its done → grant order 0,1,2,3,0. Requester 2 alone after a grant to 3 still wins.
- start==end=5 → done at cycle 4, cnt_run never asserted.
- Abort mid-RUN, plus abort and end-match in the same cycle → cnt_reset and aborted pulse for 1 cycle, no done, IDLE next cycle, pending request granted afterwards.
- Async reset low mid-RUN → all outputs 0 and cnt_reset=1 immediately. After release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/counter_job_scheduler.sv
// Purpose : time-shares one external up/down counter among NUM_REQ requesters; round-robin grant, load, run to end value, report.
// Latency : req_valid at cycle 0 -> req_ready at 1, cnt_load_en at 2, RUN from 3, done[owner] at 4 + distance(start, end).
// Backpr. : a requester holds req_valid until its one-cycle req_ready pulse; only one job is active, and others wait with valid high.
//
// Ports:
//   CLK, reset (async, active-low)
//   req_valid/req_start/req_end/req_up : per-requester job request (slice i belongs to requester i)
//   req_ready                           : one-hot acceptance pulse (GRANT cycle)
//   abort                               : kills the active job (GRANT/LOAD/RUN only)
//   cnt_out                             : value fed back from the shared counter
//   cnt_load_en/cnt_load_val/cnt_chnge/cnt_run/cnt_reset : counter controls
//   busy, owner                         : job-owned flag and owner index
//   done, aborted                       : completion pulse (one-hot) and abort pulse
module counter_job_scheduler #(
    parameter int BIT_WIDTH = 4,
    parameter int NUM_REQ   = 4,
    parameter int IDXW      = $clog2(NUM_REQ)
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_start,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_end,
    input  logic [NUM_REQ-1:0]           req_up,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         abort,
    input  logic [BIT_WIDTH-1:0]         cnt_out,
    output logic                         cnt_load_en,
    output logic [BIT_WIDTH-1:0]         cnt_load_val,
    output logic                         cnt_chnge,
    output logic                         cnt_run,
    output logic                         cnt_reset,
    output logic                         busy,
    output logic [IDXW-1:0]              owner,
    output logic [NUM_REQ-1:0]           done,
    output logic                         aborted
);

    localparam int CW = IDXW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    typedef struct packed {
        logic [BIT_WIDTH-1:0] start_val;
        logic [BIT_WIDTH-1:0] end_val;
        logic                 up;
    } job_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] rr_ptr;
    job_t            job_q;
    job_t            sel_job;

    logic            win_vld;
    logic [IDXW-1:0] win_idx;
    logic [CW-1:0]   cand;
    logic            end_hit;

    // Round-robin pick: scan offsets from farthest to nearest so the
    // nearest set bit at or above rr_ptr is the last (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (req_valid[cand[IDXW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDXW-1:0];
            end
        end
    end

    // Owner's request slices, captured at the end of the GRANT cycle.
    always_comb begin
        sel_job.start_val = req_start[owner*BIT_WIDTH +: BIT_WIDTH];
        sel_job.end_val   = req_end[owner*BIT_WIDTH +: BIT_WIDTH];
        sel_job.up        = req_up[owner];
    end

    assign end_hit = (cnt_out == job_q.end_val);

    // State register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort wins over the end match in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_vld) state_nxt = S_GRANT;
            S_GRANT: state_nxt = abort ? S_ABORT : S_LOAD;
            S_LOAD:  state_nxt = abort ? S_ABORT : S_RUN;
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_ABORT;
                end else if (end_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Owner, round-robin pointer and captured job.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            owner  <= '0;
            rr_ptr <= '0;
            job_q  <= '0;
        end else begin
            if (state == S_IDLE && win_vld) begin
                owner <= win_idx;
            end
            if (state == S_GRANT) begin
                job_q  <= sel_job;
                rr_ptr <= (owner == IDXW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

    // Outputs. cnt_run is decoded from the live cnt_out so the counter
    // stops on the exact cycle it reaches the end value.
    always_comb begin
        req_ready    = '0;
        done         = '0;
        cnt_load_en  = 1'b0;
        cnt_load_val = '0;
        cnt_chnge    = 1'b0;
        cnt_run      = 1'b0;
        aborted      = 1'b0;
        busy         = (state != S_IDLE);
        cnt_reset    = ~reset;
        case (state)
            S_GRANT: req_ready[owner] = 1'b1;
            S_LOAD: begin
                cnt_load_en  = 1'b1;
                cnt_load_val = job_q.start_val;
                cnt_chnge    = job_q.up;
            end
            S_RUN: begin
                cnt_chnge = job_q.up;
                cnt_run   = ~end_hit;
            end
            S_DONE:  done[owner] = 1'b1;
            S_ABORT: begin
                cnt_reset = 1'b1;
                aborted   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_counter_job_scheduler.sv
// Purpose : directed self-checking bench for counter_job_scheduler with a behavioural model of the shared counter.
// Latency : all expectations are hand-computed cycle numbers relative to the first req_valid cycle.
// Backpr. : requesters hold req_valid until req_ready is seen, then drop it.
module tb_counter_job_scheduler;

    localparam int BW = 4;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              CLK = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*BW-1:0]  req_start;
    logic [NR*BW-1:0]  req_end;
    logic [NR-1:0]     req_up;
    logic [NR-1:0]     req_ready;
    logic              abort;
    logic [BW-1:0]     cnt_out;
    logic              cnt_load_en;
    logic [BW-1:0]     cnt_load_val;
    logic              cnt_chnge;
    logic              cnt_run;
    logic              cnt_reset;
    logic              busy;
    logic [IW-1:0]     owner;
    logic [NR-1:0]     done;
    logic              aborted;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    counter_job_scheduler #(.BIT_WIDTH(BW), .NUM_REQ(NR)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_start(req_start), .req_end(req_end), .req_up(req_up),
        .req_ready(req_ready), .abort(abort), .cnt_out(cnt_out),
        .cnt_load_en(cnt_load_en), .cnt_load_val(cnt_load_val), .cnt_chnge(cnt_chnge),
        .cnt_run(cnt_run), .cnt_reset(cnt_reset), .busy(busy), .owner(owner),
        .done(done), .aborted(aborted)
    );

    // Shared counter model: sync clear > load > count.
    always @(posedge CLK) begin
        if (cnt_reset)        cnt_out <= '0;
        else if (cnt_load_en) cnt_out <= cnt_load_val;
        else if (cnt_run)     cnt_out <= cnt_chnge ? cnt_out + 1'b1 : cnt_out - 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic set_job(input int idx, input int s, input int e, input bit up);
        req_start[idx*BW +: BW] = BW'(s);
        req_end[idx*BW +: BW]   = BW'(e);
        req_up[idx]             = up;
    endtask

    typedef struct {
        int idx;
        int start_v;
        int end_v;
        bit up;
        int done_cyc;
    } job_vec_t;

    typedef struct {
        logic [NR-1:0] vld;
        int            win;
    } rr_vec_t;

    // Run one job from an idle scheduler and check its whole timeline.
    task automatic run_job(input job_vec_t v);
        int rdy_c = -1;
        int ld_c  = -1;
        int dn_c  = -1;
        int run_seen = 0;
        logic [NR-1:0] rdy_v = '0;
        logic [NR-1:0] dn_v  = '0;
        logic [NR-1:0] exp_oh;
        logic [BW-1:0] ld_v  = '0;
        logic          ld_dir = 1'b0;
        logic [IW-1:0] dn_own = '0;
        logic [BW-1:0] dn_cnt = '0;
        exp_oh = '0;
        exp_oh[v.idx] = 1'b1;
        @(posedge CLK); #1;
        set_job(v.idx, v.start_v, v.end_v, v.up);
        req_valid = '0;
        req_valid[v.idx] = 1'b1;
        for (int cyc = 0; cyc < 40 && dn_c < 0; cyc++) begin
            @(negedge CLK);
            if (req_ready != '0 && rdy_c < 0) begin rdy_c = cyc; rdy_v = req_ready; end
            if (cnt_load_en && ld_c < 0) begin ld_c = cyc; ld_v = cnt_load_val; ld_dir = cnt_chnge; end
            if (cnt_run) run_seen++;
            if (done != '0) begin dn_c = cyc; dn_v = done; dn_own = owner; dn_cnt = cnt_out; end
            @(posedge CLK); #1;
            if (rdy_c >= 0) req_valid[v.idx] = 1'b0;
        end
        if (dn_c < 0) timeout_fail("job_done_wait");
        check("job_ready_cycle", rdy_c, 1);
        check("job_ready_onehot", rdy_v, exp_oh);
        check("job_load_cycle", ld_c, 2);
        check("job_load_val", ld_v, v.start_v);
        check("job_load_dir", ld_dir, v.up);
        check("job_done_cycle", dn_c, v.done_cyc);
        check("job_done_onehot", dn_v, exp_oh);
        check("job_done_owner", dn_own, v.idx);
        check("job_done_cnt", dn_cnt, v.end_v);
        check("job_run_cycles", run_seen, v.done_cyc - 4);
        @(negedge CLK);
        check("job_idle_busy", busy, 0);
        check("job_hold_cnt", cnt_out, v.end_v);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge CLK);
        while (busy && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 60) timeout_fail(name);
    endtask

    job_vec_t vecs[7];
    rr_vec_t  rr[9];

    initial begin
        // idx, start, end, up, done cycle = 4 + count distance
        vecs[0] = '{0,  3,  7, 1'b1,  8};
        vecs[1] = '{1, 14,  1, 1'b1,  7};
        vecs[2] = '{1,  1, 14, 1'b0,  7};
        vecs[3] = '{2,  5,  5, 1'b1,  4};
        vecs[4] = '{3,  0, 15, 1'b0,  5};
        vecs[5] = '{0,  9,  2, 1'b0, 11};
        vecs[6] = '{3,  2,  1, 1'b1, 19};

        rr[0] = '{4'b1111, 0};
        rr[1] = '{4'b1111, 1};
        rr[2] = '{4'b1111, 2};
        rr[3] = '{4'b1111, 3};
        rr[4] = '{4'b1111, 0};
        rr[5] = '{4'b1010, 1};
        rr[6] = '{4'b1010, 3};
        rr[7] = '{4'b0100, 2};
        rr[8] = '{4'b0011, 0};

        reset     = 1'b0;
        req_valid = '0;
        req_start = '0;
        req_end   = '0;
        req_up    = '0;
        abort     = 1'b0;

        // Reset state
        #2;
        check("rst_ready", req_ready, 0);
        check("rst_load_en", cnt_load_en, 0);
        check("rst_load_val", cnt_load_val, 0);
        check("rst_chnge", cnt_chnge, 0);
        check("rst_run", cnt_run, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_cnt_reset", cnt_reset, 1);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        #1;
        check("rst_release_cnt_reset", cnt_reset, 0);

        // Table-driven single jobs
        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Round-robin order
        do_reset();
        req_start = {NR{4'd5}};
        req_end   = {NR{4'd5}};
        req_up    = '1;
        for (int i = 0; i < 9; i++) begin
            int n = 0;
            int got = -1;
            wait_idle("rr_idle_wait");
            req_valid = rr[i].vld;
            @(negedge CLK);
            while (req_ready == '0 && n < 20) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 20) timeout_fail("rr_ready_wait");
            for (int b = 0; b < NR; b++) if (req_ready[b]) got = b;
            check("rr_onehot", $countones(req_ready), 1);
            check("rr_grant", got, rr[i].win);
            req_valid = '0;
        end
        wait_idle("rr_final_idle");

        // Abort mid-RUN with a second requester pending
        do_reset();
        set_job(0, 0, 10, 1'b1);
        set_job(1, 5, 5, 1'b1);
        begin
            int n_done = 0;
            @(posedge CLK);
            for (int c = 0; c < 10; c++) begin
                #1;
                if (c == 0) req_valid = 4'b0011;
                if (c == 2) req_valid[0] = 1'b0;
                if (c == 9) req_valid[1] = 1'b0;
                abort = (c == 5);
                @(negedge CLK);
                if (c < 8 && done != '0) n_done++;
                if (c == 1) check("abA_ready0", req_ready, 4'b0001);
                if (c == 5) check("abA_cnt_c5", cnt_out, 2);
                if (c == 5) check("abA_noabort_c5", aborted, 0);
                if (c == 6) begin
                    check("abA_aborted", aborted, 1);
                    check("abA_cnt_reset", cnt_reset, 1);
                    check("abA_run_off", cnt_run, 0);
                    check("abA_done_off", done, 0);
                end
                if (c == 7) begin
                    check("abA_pulse_end", aborted, 0);
                    check("abA_idle", busy, 0);
                    check("abA_cnt_cleared", cnt_out, 0);
                    check("abA_cnt_reset_end", cnt_reset, 0);
                end
                if (c == 8) check("abA_pending_grant", req_ready, 4'b0010);
                @(posedge CLK);
            end
            check("abA_no_done", n_done, 0);
            abort = 1'b0;
        end
        wait_idle("abA_idle_wait");

        // Abort in the same cycle as the end match
        do_reset();
        set_job(2, 3, 5, 1'b1);
        begin
            @(posedge CLK);
            for (int c = 0; c < 8; c++) begin
                #1;
                if (c == 0) req_valid = 4'b0100;
                if (c == 2) req_valid = '0;
                abort = (c == 5);
                @(negedge CLK);
                if (c == 5) check("abB_match_c5", cnt_out, 5);
                if (c == 6) begin
                    check("abB_aborted", aborted, 1);
                    check("abB_done_off", done, 0);
                    check("abB_cnt_reset", cnt_reset, 1);
                end
                if (c == 7) begin
                    check("abB_done_after", done, 0);
                    check("abB_idle", busy, 0);
                    check("abB_cnt_cleared", cnt_out, 0);
                end
                @(posedge CLK);
            end
            abort = 1'b0;
        end

        // Async reset mid-RUN; afterwards the lowest valid index wins
        set_job(2, 0, 12, 1'b1);
        set_job(1, 4, 4, 1'b1);
        set_job(3, 4, 4, 1'b1);
        begin
            int n = 0;
            @(posedge CLK);
            for (int c = 0; c < 6; c++) begin
                #1;
                if (c == 0) req_valid = 4'b0100;
                if (c == 2) req_valid = '0;
                @(negedge CLK);
                if (c == 5) begin
                    check("rstmid_busy_before", busy, 1);
                    check("rstmid_run_before", cnt_run, 1);
                end
                if (c < 5) @(posedge CLK);
            end
            #2;
            reset = 1'b0;
            #1;
            check("rstmid_busy", busy, 0);
            check("rstmid_run", cnt_run, 0);
            check("rstmid_load_en", cnt_load_en, 0);
            check("rstmid_ready", req_ready, 0);
            check("rstmid_done", done, 0);
            check("rstmid_aborted", aborted, 0);
            check("rstmid_owner", owner, 0);
            check("rstmid_cnt_reset", cnt_reset, 1);
            req_valid = 4'b1010;
            repeat (2) @(negedge CLK);
            reset = 1'b1;
            @(negedge CLK);
            while (req_ready == '0 && n < 20) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 20) timeout_fail("rstmid_ready_wait");
            check("rstmid_first_grant", req_ready, 4'b0010);
            req_valid = 4'b1000;
            wait_idle("rstmid_idle1");
            wait_idle("rstmid_idle2");
            req_valid = '0;
            wait_idle("rstmid_idle3");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
